// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state encodings and default operand width for the ALU front end.
package alu_pkg;
    localparam int ALU_WIDTH = 3;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT_B  = 2'b01,
        ST_PRESENT = 2'b10
    } alu_state_t;
endpackage

// File: rtl/key_press_detect.sv
// key_press_detect: active-low key to one-cycle press pulse; OPLOAD_DEBOUNCE_EN adds a synchroniser and debounce filter.
module key_press_detect #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_n,
    output logic press
);
    logic level, prev, armed;
`ifdef OPLOAD_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic sync_1, sync_2, lvl_q;
    logic [CW-1:0] cnt;
    // filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            lvl_q  <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            if (sync_2 == lvl_q) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                lvl_q <= sync_2;
                cnt   <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
    assign level = lvl_q;
`else
    assign level = key_n;
`endif
    // armed stays low until the key is seen released, so a key held through reset is not a press
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev  <= 1'b1;
            armed <= 1'b0;
        end else begin
            prev  <= level;
            armed <= armed | level;
        end
    end
    assign press = armed & prev & ~level;
endmodule

// File: rtl/operand_loader.sv
// operand_loader: captures two operands from a switch bus on key presses and holds them valid until ack.
// Optional debounce on load_n enabled by defining OPLOAD_DEBOUNCE_EN.
module operand_loader
    import alu_pkg::*;
#(
    parameter int WIDTH           = ALU_WIDTH,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             load_n,
    input  logic             clear,
    input  logic             ack,
    output logic [WIDTH-1:0] num_1,
    output logic [WIDTH-1:0] num_2,
    output logic             valid,
    output logic [1:0]       state_dbg
);
    alu_state_t state;
    logic press;
    key_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk   (clk),
        .resetn(resetn),
        .key_n (load_n),
        .press (press)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            num_1 <= '0;
            num_2 <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            state <= ST_IDLE;
            num_1 <= '0;
            num_2 <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (press) begin
                    num_1 <= sw_data;
                    state <= ST_WAIT_B;
                end
                ST_WAIT_B: if (press) begin
                    num_2 <= sw_data;
                    state <= ST_PRESENT;
                    valid <= 1'b1;
                end
                ST_PRESENT: if (ack) begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end
    assign state_dbg = state;
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed and random stimulus against a behavioural model of the operand loader.
module tb_operand_loader;
    logic clk = 1'b0, resetn = 1'b0, load_n = 1'b1, clear = 1'b0, ack = 1'b0;
    logic [2:0] sw_data = '0;
    logic [2:0] num_1, num_2;
    logic valid;
    logic [1:0] state_dbg;
    int checks = 0, failures = 0;
    int m_phase;
    logic [2:0] m_n1, m_n2;
    logic m_prev, m_seen_high;

    operand_loader dut (
        .clk(clk), .resetn(resetn), .sw_data(sw_data), .load_n(load_n),
        .clear(clear), .ack(ack), .num_1(num_1), .num_2(num_2),
        .valid(valid), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_n1 = '0; m_n2 = '0; m_prev = 1'b1; m_seen_high = 1'b0;
    endtask

    task automatic cmp_all(input string tag);
        check({tag, ".num_1"}, 32'(num_1), 32'(m_n1));
        check({tag, ".num_2"}, 32'(num_2), 32'(m_n2));
        check({tag, ".valid"}, 32'(valid), 32'(m_phase == 2));
        check({tag, ".state"}, 32'(state_dbg), 32'(m_phase));
    endtask

    // One clock: drive at negedge, let the edge happen, advance the model, compare.
    task automatic step(input logic [2:0] sw, input logic ld, input logic cl, input logic ak, input string tag);
        logic pressed;
        @(negedge clk);
        sw_data = sw; load_n = ld; clear = cl; ack = ak;
        @(posedge clk);
        #1;
        pressed = m_seen_high && m_prev && !ld;
        m_seen_high = m_seen_high || ld;
        m_prev = ld;
        if (cl) begin
            m_phase = 0; m_n1 = '0; m_n2 = '0;
        end else if (m_phase == 2) begin
            if (ak) m_phase = 0;
        end else if (pressed) begin
            if (m_phase == 0) begin m_n1 = sw; m_phase = 1; end
            else begin m_n2 = sw; m_phase = 2; end
        end
        cmp_all(tag);
    endtask

    task automatic press_with(input logic [2:0] sw, input string tag);
        step(sw, 1'b0, 1'b0, 1'b0, tag);
        step(sw, 1'b1, 1'b0, 1'b0, {tag, ".rel"});
    endtask

    initial begin
        model_reset();
        #12;
        cmp_all("reset");
        @(negedge clk) resetn = 1'b1;
        step(3'd0, 1'b1, 1'b0, 1'b0, "idle");

        // two loads then presentation
        press_with(3'd3, "t1.p1");
        check("t1.wait_state", 32'(state_dbg), 32'd1);
        press_with(3'd5, "t1.p2");
        check("t1.num_1", 32'(num_1), 32'd3);
        check("t1.num_2", 32'(num_2), 32'd5);
        check("t1.valid", 32'(valid), 32'd1);

        // presses ignored while presenting, ack releases but keeps operands
        press_with(3'd7, "t2.ignored");
        check("t2.num_1", 32'(num_1), 32'd3);
        step(3'd7, 1'b1, 1'b0, 1'b1, "t2.ack");
        check("t2.valid", 32'(valid), 32'd0);
        check("t2.num_2", 32'(num_2), 32'd5);

        // ack outside PRESENT is ignored
        step(3'd1, 1'b1, 1'b0, 1'b1, "ack_idle");

        // long hold gives exactly one capture
        for (int i = 0; i < 20; i++) step(3'(i), 1'b0, 1'b0, 1'b0, "t3.hold");
        step(3'd2, 1'b1, 1'b0, 1'b0, "t3.rel");
        check("t3.state", 32'(state_dbg), 32'd1);
        check("t3.num_1", 32'(num_1), 32'd0);

        // clear wins over simultaneous press
        step(3'd2, 1'b1, 1'b1, 1'b0, "t4.pre_clr");
        press_with(3'd6, "t4.load6");
        check("t4.num_1", 32'(num_1), 32'd6);
        step(3'd4, 1'b0, 1'b1, 1'b0, "t4.clr_press");
        check("t4.state", 32'(state_dbg), 32'd0);
        step(3'd4, 1'b1, 1'b0, 1'b0, "t4.rel");

        // press and ack together in PRESENT: ack wins
        press_with(3'd1, "t6.a");
        press_with(3'd2, "t6.b");
        step(3'd5, 1'b0, 1'b0, 1'b1, "t6.ack_press");
        step(3'd5, 1'b1, 1'b0, 1'b0, "t6.rel");
        check("t6.num_1", 32'(num_1), 32'd1);

        // async reset mid-PRESENT with key held through it
        press_with(3'd4, "t5.a");
        press_with(3'd2, "t5.b");
        check("t5.valid_pre", 32'(valid), 32'd1);
        #2;
        resetn = 1'b0; load_n = 1'b0;
        #1;
        model_reset();
        cmp_all("t5.async");
        @(negedge clk) resetn = 1'b1;
        for (int i = 0; i < 5; i++) step(3'd7, 1'b0, 1'b0, 1'b0, "t5.held");
        check("t5.no_capture", 32'(state_dbg), 32'd0);
        step(3'd7, 1'b1, 1'b0, 1'b0, "t5.rel");
        press_with(3'd3, "t5.repress");
        check("t5.captured", 32'(num_1), 32'd3);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
